// File: rtl/id_ex_reg_pkg.sv
// Shared decode/execute definitions: control-bundle field positions and the ID/EX data payload.
package id_ex_reg_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned CTRL_W_DEF = 12;

  // Control-bundle bit positions agreed between decode and execute
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;
  localparam int unsigned CTRL_BRANCH     = 6;
  localparam int unsigned CTRL_JUMP       = 7;
  localparam int unsigned CTRL_ALU_OP_LSB = 8;
  localparam int unsigned CTRL_ALU_OP_W   = 4;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
    logic [XLEN-1:0]  imm32;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_data_t;

endpackage

// File: rtl/id_ex_reg_load_use.sv
// Load-use hazard comparator: a load in EX whose destination feeds the instruction in ID.
module load_use_detect
  import id_ex_reg_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);

  logic rs_match;
  logic rt_match;

  // $0 is hard-wired, so a load targeting it never creates a dependency
  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
  assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i
                  & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, execute back-pressure and optional load-use bubble insertion.
// Optional feature: define ID_EX_LOAD_USE_DETECT_EN to enable hazard detection and bubble_cnt.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rt_data,
  input  logic [XLEN-1:0]   id_imm32,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs_data,
  output logic [XLEN-1:0]   ex_rt_data,
  output logic [XLEN-1:0]   ex_imm32,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_data_t        data_q, data_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              hazard;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
    .ex_rt_i       (data_q.rt),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .hazard_o      (hazard)
  );

  // Bubble counter saturates rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && !ex_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  logic unused_id_uses_rt;

  assign unused_id_uses_rt = id_uses_rt;
  assign hazard            = 1'b0;
  assign bubble_cnt        = '0;
`endif

  // Priority: flush > ex_stall > hazard bubble > load; data fields hold when squashed
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!ex_stall) begin
      if (hazard) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d        = id_valid;
        ctrl_d         = id_valid ? id_ctrl : '0;
        data_d.pc      = id_pc;
        data_d.rs_data = id_rs_data;
        data_d.rt_data = id_rt_data;
        data_d.imm32   = id_imm32;
        data_d.rs      = id_rs;
        data_d.rt      = id_rt;
        data_d.rd      = id_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign id_stall   = ex_stall | (hazard & ~flush);
  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_pc      = data_q.pc;
  assign ex_rs_data = data_q.rs_data;
  assign ex_rt_data = data_q.rt_data;
  assign ex_imm32   = data_q.imm32;
  assign ex_rs      = data_q.rs;
  assign ex_rt      = data_q.rt;
  assign ex_rd      = data_q.rd;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg; expectations adapt to ID_EX_LOAD_USE_DETECT_EN.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  localparam int unsigned CW = 12;
  localparam int unsigned NW = 4;
  localparam logic [CW-1:0] LW_CTRL  = 12'h01B;
  localparam logic [CW-1:0] ADD_CTRL = 12'h121;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rt, flush, ex_stall;
  logic [31:0]   id_pc, id_rs_data, id_rt_data, id_imm32;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [CW-1:0] id_ctrl;
  logic          ex_valid, id_stall;
  logic [31:0]   ex_pc, ex_rs_data, ex_rt_data, ex_imm32;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] bubble_cnt;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [31:0]   pc, rs_data, rt_data, imm;
    logic [4:0]    rs, rt, rd;
    logic [NW-1:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  id_ex_reg #(.CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm32(ex_imm32), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic model_hazard();
`ifdef ID_EX_LOAD_USE_DETECT_EN
    return m.valid && m.ctrl[CTRL_MEM_READ] && (m.rt != 5'd0) && id_valid &&
           ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    id_valid = 1'b0; id_uses_rt = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm32 = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0;
  endtask

  task automatic set_instr(input logic [CW-1:0] ctrl, input logic [31:0] pc,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt);
    id_valid = 1'b1; id_ctrl = ctrl; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = uses_rt;
    id_rs_data = pc ^ 32'hA5A5_0000; id_rt_data = pc ^ 32'h0000_5A5A; id_imm32 = ~pc;
  endtask

  // One clock: check id_stall, push predicted EX state, compare it after the edge
  task automatic tick(input string tag);
    exp_t nx;
    exp_t e;
    logic hz;
    logic want_stall;
    #1;
    hz = model_hazard();
    want_stall = ex_stall | (hz & ~flush);
    n_cmp++;
    if (id_stall !== want_stall) begin
      n_bad++;
      $display("FAIL %s id_stall: got %0b want %0b", tag, id_stall, want_stall);
    end
    nx = m;
    if (flush) begin
      nx.valid = 1'b0; nx.ctrl = '0;
    end else if (ex_stall) begin
      nx = m;
    end else if (hz) begin
      nx.valid = 1'b0; nx.ctrl = '0;
      nx.cnt = (m.cnt == 4'hF) ? m.cnt : m.cnt + 4'd1;
    end else begin
      nx.valid = id_valid;
      nx.ctrl = id_valid ? id_ctrl : '0;
      nx.pc = id_pc; nx.rs_data = id_rs_data; nx.rt_data = id_rt_data; nx.imm = id_imm32;
      nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
    end
    sb.push_back(nx);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (ex_valid !== e.valid) begin
        n_bad++;
        $display("FAIL %s ex_valid: got %0b want %0b", tag, ex_valid, e.valid);
      end
      n_cmp++;
      if (ex_ctrl !== e.ctrl) begin
        n_bad++;
        $display("FAIL %s ex_ctrl: got %h want %h", tag, ex_ctrl, e.ctrl);
      end
      n_cmp++;
      if (bubble_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s bubble_cnt: got %0d want %0d", tag, bubble_cnt, e.cnt);
      end
      if (e.valid) begin
        n_cmp++;
        if ({ex_pc, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_rd} !==
            {e.pc, e.rs_data, e.rt_data, e.imm, e.rs, e.rt, e.rd}) begin
          n_bad++;
          $display("FAIL %s data: got pc=%h imm=%h rs/rt/rd=%0d/%0d/%0d want pc=%h imm=%h rs/rt/rd=%0d/%0d/%0d",
                   tag, ex_pc, ex_imm32, ex_rs, ex_rt, ex_rd, e.pc, e.imm, e.rs, e.rt, e.rd);
        end
      end
      m = e;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm32, ex_rs, ex_rt, ex_rd, bubble_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got valid=%0b ctrl=%h pc=%h cnt=%0d want all zero",
               ex_valid, ex_ctrl, ex_pc, bubble_cnt);
    end
    n_cmp++;
    if (id_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset id_stall: got %0b want 0", id_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    m = '0;
  endtask

  task automatic test_load_through();
    set_instr(ADD_CTRL, 32'h0000_0010, 5'd1, 5'd2, 5'd3, 1'b1);
    id_imm32 = 32'hFFFF_FFF8;
    tick("load_through");
    n_cmp++;
    if (ex_pc !== 32'h0000_0010 || ex_imm32 !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL load_through fixed: got pc=%h imm=%h want 00000010 fffffff8", ex_pc, ex_imm32);
    end
    id_valid = 1'b0;
    tick("invalid_id");
  endtask

  task automatic test_load_use();
    set_instr(LW_CTRL, 32'h100, 5'd2, 5'd5, 5'd0, 1'b0);
    tick("lu_lw");
    set_instr(ADD_CTRL, 32'h104, 5'd5, 5'd6, 5'd7, 1'b1);
    tick("lu_dep");
    tick("lu_release");
    idle_inputs();
    tick("lu_idle");
  endtask

  task automatic test_zero_and_unused_rt();
    set_instr(LW_CTRL, 32'h200, 5'd1, 5'd0, 5'd0, 1'b0);
    tick("zero_lw");
    set_instr(ADD_CTRL, 32'h204, 5'd0, 5'd0, 5'd9, 1'b1);
    tick("zero_dep");
    set_instr(LW_CTRL, 32'h208, 5'd1, 5'd7, 5'd0, 1'b0);
    tick("rt_lw");
    set_instr(ADD_CTRL, 32'h20C, 5'd3, 5'd7, 5'd9, 1'b0);
    tick("rt_unused");
    set_instr(LW_CTRL, 32'h210, 5'd1, 5'd7, 5'd0, 1'b0);
    tick("rt_lw2");
    set_instr(ADD_CTRL, 32'h214, 5'd3, 5'd7, 5'd9, 1'b1);
    tick("rt_used");
    tick("rt_used_release");
  endtask

  task automatic test_flush_vs_stall();
    set_instr(LW_CTRL, 32'h300, 5'd1, 5'd5, 5'd0, 1'b0);
    tick("fl_lw");
    set_instr(ADD_CTRL, 32'h304, 5'd5, 5'd1, 5'd2, 1'b1);
    flush = 1'b1; ex_stall = 1'b1;
    tick("flush_stall_hazard");
    flush = 1'b0; ex_stall = 1'b0;
    tick("fl_after");
  endtask

  task automatic test_stall_hold();
    set_instr(ADD_CTRL, 32'h400, 5'd4, 5'd8, 5'd12, 1'b1);
    tick("st_load");
    set_instr(LW_CTRL, 32'h404, 5'd9, 5'd10, 5'd0, 1'b0);
    ex_stall = 1'b1;
    tick("st_hold1");
    tick("st_hold2");
    ex_stall = 1'b0;
    tick("st_release");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      set_instr(12'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      id_valid = ($urandom_range(0, 3) != 0);
      tick("b2b");
    end
    idle_inputs();
    tick("b2b_idle");
  endtask

  task automatic test_saturation();
    logic [NW-1:0] want;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_instr(LW_CTRL, 32'h500, 5'd1, 5'd3, 5'd0, 1'b0);
      tick("sat_lw");
      set_instr(ADD_CTRL, 32'h504, 5'd3, 5'd4, 5'd5, 1'b0);
      tick("sat_dep");
    end
`ifdef ID_EX_LOAD_USE_DETECT_EN
    want = 4'hF;
`else
    want = 4'h0;
`endif
    n_cmp++;
    if (bubble_cnt !== want) begin
      n_bad++;
      $display("FAIL saturation bubble_cnt: got %0d want %0d", bubble_cnt, want);
    end
  endtask

  task automatic test_async_reset();
    set_instr(LW_CTRL, 32'h600, 5'd1, 5'd6, 5'd0, 1'b0);
    tick("ar_lw");
    set_instr(ADD_CTRL, 32'h604, 5'd6, 5'd1, 5'd2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ex_valid !== 1'b0 || bubble_cnt !== '0 || ex_pc !== '0 || ex_ctrl !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got valid=%0b cnt=%0d pc=%h ctrl=%h want zeros",
               ex_valid, bubble_cnt, ex_pc, ex_ctrl);
    end
    n_cmp++;
    if (id_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset id_stall idle: got %0b want 0", id_stall);
    end
    ex_stall = 1'b1;
    #1;
    n_cmp++;
    if (id_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset id_stall tracks ex_stall: got %0b want 1", id_stall);
    end
    ex_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m = '0;
    sb.delete();
    tick("ar_first_edge");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m = '0;
    test_reset();
    test_load_through();
    test_load_use();
    test_zero_and_unused_rt();
    test_flush_vs_stall();
    test_stall_hold();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
